// File: rtl/axis_read_data_core.sv
// Read-side width converter: buffers wide AXI read beats in a FIFO and
// serializes each beat into WIDTH_RATIO narrow words, lowest word first.
module axis_read_data_core #(
  parameter int BUF_AWIDTH     = 4,
  parameter int CONFIG_DWIDTH  = 32,
  parameter int WIDTH_RATIO    = 8,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      valid,
  input  logic                      ready
);

  localparam int IDX_W = (WIDTH_RATIO > 1) ? $clog2(WIDTH_RATIO) : 1;
  localparam logic [IDX_W-1:0]         IDX_LAST   = IDX_W'(WIDTH_RATIO - 1);
  localparam logic [IDX_W-1:0]         IDX_ONE    = IDX_W'(1);
  localparam logic [CONFIG_DWIDTH-1:0] CFG_ONE    = CONFIG_DWIDTH'(1);
  localparam logic [CONFIG_DWIDTH-1:0] CFG_ZERO   = CONFIG_DWIDTH'(0);
  localparam logic [BUF_AWIDTH:0]      FULL_COUNT = {1'b1, {BUF_AWIDTH{1'b0}}};
  localparam logic [BUF_AWIDTH:0]      CNT_ONE    = (BUF_AWIDTH+1)'(1);
  localparam logic [BUF_AWIDTH-1:0]    PTR_ONE    = BUF_AWIDTH'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                    state_r;
  logic [CONFIG_DWIDTH-1:0]  len_r;
  logic [CONFIG_DWIDTH-1:0]  cnt_r;
  logic [AXI_DATA_WIDTH-1:0] mem_r [2**BUF_AWIDTH];
  logic [BUF_AWIDTH-1:0]     wr_ptr_r;
  logic [BUF_AWIDTH-1:0]     rd_ptr_r;
  logic [BUF_AWIDTH:0]       count_r;
  logic [AXI_DATA_WIDTH-1:0] beat_r;
  logic                      held_r;
  logic [IDX_W-1:0]          idx_r;
  logic [DATA_WIDTH-1:0]     data_r;

  logic [DATA_WIDTH-1:0]     words_s [WIDTH_RATIO];
  logic [AXI_DATA_WIDTH-1:0] fifo_head_s;
  logic                      full_s;
  logic                      push_s;
  logic                      pop_s;
  logic                      valid_s;
  logic                      consume_s;
  logic                      last_word_s;
  logic                      release_s;

  for (genvar k = 0; k < WIDTH_RATIO; k++) begin : g_words
    assign words_s[k] = beat_r[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign fifo_head_s = mem_r[rd_ptr_r];
  assign full_s      = (count_r == FULL_COUNT);
  assign push_s      = axi_rvalid & ~full_s;
  assign valid_s     = (state_r == ACTIVE) & held_r;
  assign consume_s   = valid_s & ready;
  assign last_word_s = (cnt_r == (len_r - CFG_ONE));
  // A beat is released on its last word or when the transfer ends mid-beat.
  assign release_s   = consume_s & ((idx_r == IDX_LAST) | last_word_s);
  assign pop_s       = (count_r != '0) & (~held_r | release_s);

  assign cfg_ready  = (state_r == IDLE);
  assign axi_rready = ~full_s;
  assign valid      = valid_s;
  assign data       = data_r;

  // FIFO storage, written without reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= axi_rdata;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Holding register and word index of the serializer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_r <= '0;
      held_r <= 1'b0;
      idx_r  <= '0;
      data_r <= '0;
    end else if (pop_s) begin
      beat_r <= fifo_head_s;
      held_r <= 1'b1;
      idx_r  <= '0;
      data_r <= fifo_head_s[DATA_WIDTH-1:0];
    end else if (release_s) begin
      held_r <= 1'b0;
      idx_r  <= '0;
    end else if (consume_s) begin
      idx_r  <= idx_r + IDX_ONE;
      data_r <= words_s[idx_r + IDX_ONE];
    end
  end

  // Transfer FSM with length and consumed-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      len_r   <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cfg_valid) begin
            len_r <= cfg_length;
            cnt_r <= '0;
            if (cfg_length != CFG_ZERO) begin
              state_r <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (consume_s) begin
            cnt_r <= cnt_r + CFG_ONE;
            if (last_word_s) begin
              state_r <= IDLE;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_read_data_core.sv
// Directed bench for axis_read_data_core with a word scoreboard.
module tb_axis_read_data_core;

  localparam int DW  = 32;
  localparam int R   = 8;
  localparam int ADW = 256;

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    cfg_length;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [ADW-1:0] axi_rdata;
  logic           axi_rvalid;
  logic           axi_rready;
  logic [DW-1:0]  data;
  logic           valid;
  logic           ready;

  int checks = 0;
  int failures = 0;
  int words_seen = 0;
  logic [DW-1:0] sb[$];

  axis_read_data_core dut (
    .clk(clk), .rst(rst),
    .cfg_length(cfg_length), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .data(data), .valid(valid), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADW-1:0] mk_beat(input int base);
    logic [ADW-1:0] b;
    b = '0;
    for (int k = 0; k < R; k++) b[k*DW +: DW] = DW'(base + k);
    return b;
  endfunction

  task automatic exp_push(input int base, input int n);
    for (int i = 0; i < n; i++) sb.push_back(DW'(base + i));
  endtask

  task automatic push_beat(input int base);
    int n;
    n = 0;
    axi_rdata  = mk_beat(base);
    axi_rvalid = 1'b1;
    while (!axi_rready && n < 200) begin
      tick();
      n++;
    end
    check("rready_before_push", {63'd0, axi_rready}, 64'd1);
    tick();
    axi_rvalid = 1'b0;
  endtask

  task automatic send_cfg(input int len);
    check("cfg_ready_before_cfg", {63'd0, cfg_ready}, 64'd1);
    cfg_length = 32'(len);
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (!(sb.size() == 0 && !valid) && n < 500) begin
      tick();
      n++;
    end
    check(tag, {63'd0, (sb.size() == 0 && !valid)}, 64'd1);
    check({tag, "_cfg_ready"}, {63'd0, cfg_ready}, 64'd1);
  endtask

  task automatic wait_words(input int target);
    int n;
    n = 0;
    while (words_seen < target && n < 500) begin
      tick();
      n++;
    end
    check("words_reached", {63'd0, words_seen >= target}, 64'd1);
  endtask

  // Output monitor: every accepted word must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (sb.size() == 0) begin
        check("extra_word", {32'd0, data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("data_word", {32'd0, data}, {32'd0, sb.pop_front()});
      end
      words_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] held_word;
    rst = 1'b1; cfg_length = '0; cfg_valid = 1'b0;
    axi_rdata = '0; axi_rvalid = 1'b0; ready = 1'b0;
    tick(); tick();
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_data", {32'd0, data}, 64'd0);
    check("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    check("rst_axi_rready", {63'd0, axi_rready}, 64'd1);
    rst = 1'b0;
    tick();

    // Length 10 across two beats, ready high
    ready = 1'b1;
    exp_push(1, 8); exp_push(2, 2);
    send_cfg(10);
    push_beat(1);
    push_beat(2);
    wait_drain("len10_drain");

    // Same transfer with ready stalled mid-stream
    exp_push(1, 8); exp_push(2, 2);
    send_cfg(10);
    push_beat(1);
    push_beat(2);
    wait_words(14);
    ready = 1'b0;
    held_word = data;
    check("stall_front", {32'd0, data}, {32'd0, sb[0]});
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {63'd0, valid}, 64'd1);
      check("stall_data", {32'd0, data}, {32'd0, held_word});
    end
    ready = 1'b1;
    wait_drain("stall_drain");
    check("stall_word_total", 64'(words_seen), 64'd20);

    // Length 16, two beats queued ahead: no bubble at the boundary
    exp_push(17, 8); exp_push(25, 8);
    push_beat(17);
    push_beat(25);
    tick();
    send_cfg(16);
    for (int i = 0; i < 16; i++) begin
      check("b2b_valid", {63'd0, valid}, 64'd1);
      tick();
    end
    check("b2b_end_valid", {63'd0, valid}, 64'd0);
    wait_drain("b2b_drain");

    // Length 0: nothing emitted, stays idle
    send_cfg(0);
    for (int i = 0; i < 5; i++) begin
      check("len0_valid", {63'd0, valid}, 64'd0);
      check("len0_cfg_ready", {63'd0, cfg_ready}, 64'd1);
      tick();
    end

    // Fill holder plus FIFO with ready low
    ready = 1'b0;
    axi_rvalid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      axi_rdata = mk_beat(200 + 8*i);
      check("fill_rready", {63'd0, axi_rready}, 64'd1);
      tick();
    end
    axi_rvalid = 1'b0;
    check("full_rready", {63'd0, axi_rready}, 64'd0);
    exp_push(200, 8);
    send_cfg(8);
    tick();
    check("full_stalled_valid", {63'd0, valid}, 64'd1);
    check("full_still_full", {63'd0, axi_rready}, 64'd0);
    ready = 1'b1;
    wait_drain("full_drain");
    check("full_rready_back", {63'd0, axi_rready}, 64'd1);

    // Reset in the middle of the next transfer
    exp_push(208, 8);
    send_cfg(8);
    wait_words(words_seen + 3);
    rst = 1'b1;
    #1;
    check("midrst_valid", {63'd0, valid}, 64'd0);
    check("midrst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    check("midrst_axi_rready", {63'd0, axi_rready}, 64'd1);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    check("postrst_valid", {63'd0, valid}, 64'd0);
    exp_push(100, 8);
    push_beat(100);
    send_cfg(8);
    wait_drain("postrst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
